// File: rtl/mutex_arbiter_pkg.sv
// mutex_arbiter_pkg
// Shared definitions for the mutex arbiter slice: FSM state encoding and
// default parameter values used by the top, the interface and the
// request synchronizer.
package mutex_arbiter_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_IDW         = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_LIMIT  = 255;
  localparam int DEF_CNTW        = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/mutex_arbiter_if.sv
// mutex_arbiter_if
// Four-phase request/grant bundle between the requesters and the arbiter.
//   req         : per-requester request, asynchronous to clk
//   gnt         : one-hot registered grant
//   busy        : any grant active
//   owner       : index of the granted requester, valid while busy
//   timeout     : sticky grant-hold timeout flag
//   timeout_clr : synchronous clear of timeout
// Handshake: a requester raises req and holds it until it has seen gnt and
// finished; it then drops req and must see gnt low before raising req again.
// master = requester side, slave = arbiter side.
interface mutex_arbiter_if
  import mutex_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW   = DEF_IDW
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic [IDW-1:0]   owner;
  logic             timeout;
  logic             timeout_clr;

  modport master (output req, timeout_clr, input gnt, busy, owner, timeout);
  modport slave  (input req, timeout_clr, output gnt, busy, owner, timeout);
endinterface

// File: rtl/mutex_arbiter_req_sync.sv
// mutex_arbiter_req_sync
// W-bit, STAGES-deep flop synchronizer for the asynchronous request lines.
//   clk     : system clock
//   reset_n : asynchronous active-low reset, clears every stage
//   i_d     : asynchronous input bits
//   o_q     : synchronized output bits (last stage)
module mutex_arbiter_req_sync
  import mutex_arbiter_pkg::*;
#(
  parameter int W      = DEF_N_REQ,
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mutex_arbiter.sv
// mutex_arbiter
// Round-robin arbiter sharing one bridge resource among N_REQ asynchronous
// four-phase requesters. Requests are synchronized, one owner is granted at
// a time, and a dead RELEASE cycle separates successive grants.
//   clk         : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   arb         : request/grant bundle (slave side)
//   o_dbg_state : current FSM state, for observation only
module mutex_arbiter
  import mutex_arbiter_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int IDW         = DEF_IDW,
  parameter int HOLD_LIMIT  = DEF_HOLD_LIMIT,
  parameter int CNTW        = DEF_CNTW
) (
  input  logic              clk,
  input  logic              reset_n,
  mutex_arbiter_if.slave    arb,
  output state_t            o_dbg_state
);

  logic [N_REQ-1:0] w_reqs;
  logic [IDW-1:0]   w_sel;
  logic [N_REQ-1:0] w_onehot;
  logic [IDW-1:0]   w_ptr_next;
  logic [CNTW-1:0]  w_cnt_inc;
  logic             w_to_set;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_busy;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   r_ptr;
  logic [CNTW-1:0]  r_cnt;
  logic             r_timeout;

  mutex_arbiter_req_sync #(
    .W      (N_REQ),
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (arb.req),
    .o_q     (w_reqs)
  );

  // First set bit at or above ptr, wrapping; an out-of-range ptr acts as 0.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDW-1:0]   ptr);
    int         base;
    int         idx;
    logic       found;
    logic [IDW-1:0] sel;
    base  = (int'(ptr) >= N_REQ) ? 0 : int'(ptr);
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (base + k) % N_REQ;
      if (!found && r[idx]) begin
        sel   = idx[IDW-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_sel      = rr_pick(w_reqs, r_ptr);
  assign w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
  assign w_ptr_next = (r_owner >= IDW'(N_REQ-1)) ? '0 : r_owner + 1'b1;
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // Timeout fires when the hold counter steps onto HOLD_LIMIT, so the flag
  // appears in the same cycle the counter shows HOLD_LIMIT.
  assign w_to_set = (r_state == ST_GRANT) && (HOLD_LIMIT != 0) &&
                    (r_cnt != '1) && (w_cnt_inc == CNTW'(HOLD_LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      // Set has priority over a coincident clear.
      if (w_to_set)             r_timeout <= 1'b1;
      else if (arb.timeout_clr) r_timeout <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (|w_reqs) begin
            r_gnt   <= w_onehot;
            r_owner <= w_sel;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_cnt <= w_cnt_inc;
          if (!w_reqs[r_owner]) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptr_next;
            r_state <= ST_RELEASE;
          end
        end
        // Dead cycle: gnt low is seen before any new grant.
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign arb.gnt     = r_gnt;
  assign arb.busy    = r_busy;
  assign arb.owner   = r_owner;
  assign arb.timeout = r_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mutex_arbiter.sv
module tb_mutex_arbiter;
  import mutex_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int IDW  = 2;
  localparam int HL   = 5;
  localparam int CNTW = 8;
  localparam int W    = IDW;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  mutex_arbiter_if #(.N_REQ(N), .IDW(IDW)) bus ();

  mutex_arbiter #(
    .N_REQ(N), .SYNC_STAGES(SYNC), .IDW(IDW), .HOLD_LIMIT(HL), .CNTW(CNTW)
  ) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .arb         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: the arbiter sees req delayed by SYNC edges; either
  // someone owns the resource, or a dead cycle follows a release, or it
  // picks the next requester round-robin.
  logic [W-1:0]   exp_q[$];
  logic [N-1:0]   m_hist[$];
  int             m_owner;
  int             m_ptr;
  int             m_cnt;
  bit             m_dead;
  bit             m_to;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_dead = 0; m_to = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] rs;
    bit set_to;
    int idx;
    rs = m_hist.pop_front();
    m_hist.push_back(bus.req);
    set_to = 0;
    if (m_owner >= 0) begin
      if (HL != 0 && m_cnt + 1 == HL) set_to = 1;
      if (m_cnt < (1 << CNTW) - 1) m_cnt++;
      if (!rs[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_dead  = 1;
      end
    end else if (m_dead) begin
      m_dead = 0;
    end else if (rs != 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (rs[idx]) begin
          m_owner = idx;
          break;
        end
      end
      m_cnt = 0;
      exp_q.push_back(W'(m_owner));
    end
    if (set_to) m_to = 1;
    else if (bus.timeout_clr) m_to = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] eg;
  int           grant_log[$];
  bit           saw_gnt3 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      check("gnt", bus.gnt, eg);
      check("busy", bus.busy, (m_owner >= 0));
      check("timeout", bus.timeout, m_to);
      check("onehot", ($countones(bus.gnt) <= 1), 1);
      if (m_owner >= 0) check("owner", bus.owner, m_owner);
      if (bus.gnt[3]) saw_gnt3 = 1;
      if (bus.gnt != 0 && bus.gnt != prev_gnt) begin
        check("gap_before_grant", prev_gnt, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL grant_unexpected: got owner %0d expected none", bus.owner);
        end else begin
          check("grant_order", bus.owner, exp_q.pop_front());
        end
        grant_log.push_back(int'(bus.owner));
      end
      prev_gnt = bus.gnt;
    end
  end

  // ---------------- drivers ----------------
  int ag_hold[N];
  bit ag_wait_low[N];
  int ag_raise_pct;
  int ag_hold_max;
  bit ag_withdraw;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.timeout_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      ag_hold[i] = 0;
      ag_wait_low[i] = 0;
    end
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int i, input bit lvl, input int max_cyc, input string name);
    int n = 0;
    while (bus.gnt[i] !== lvl && n < max_cyc) begin
      tick(1);
      n++;
    end
    check(name, bus.gnt[i], lvl);
  endtask

  // Well-behaved four-phase requesters (with optional withdrawal).
  task automatic agents_step();
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) begin
        if (bus.gnt[i]) begin
          if (ag_hold[i] > 0) ag_hold[i]--;
          else begin
            bus.req[i] = 1'b0;
            ag_wait_low[i] = 1;
          end
        end else if (ag_withdraw && $urandom_range(0, 99) < 3) begin
          bus.req[i] = 1'b0;
          ag_wait_low[i] = 1;
        end
      end else if (ag_wait_low[i]) begin
        if (!bus.gnt[i]) ag_wait_low[i] = 0;
      end else if ($urandom_range(0, 99) < ag_raise_pct) begin
        bus.req[i] = 1'b1;
        ag_hold[i] = $urandom_range(0, ag_hold_max);
      end
    end
  endtask

  // ---------------- tests ----------------
  int order_exp[5] = '{0, 1, 2, 3, 0};
  int n;

  initial begin
    bus.req = '0;
    bus.timeout_clr = 1'b0;
    ag_raise_pct = 0; ag_hold_max = 0; ag_withdraw = 0;

    // 1: reset state and single-request latency
    do_reset();
    check("rst_gnt", bus.gnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_state", dbg_state, ST_IDLE);
    bus.req = 4'b0100;
    tick(2);
    check("t1_gnt_early", bus.gnt, 0);
    tick(1);
    check("t1_gnt", bus.gnt, 4'b0100);
    check("t1_owner", bus.owner, 2);
    bus.req = '0;
    tick(2);
    check("t1_hold", bus.gnt, 4'b0100);
    tick(1);
    check("t1_release_gnt", bus.gnt, 0);
    check("t1_release_busy", bus.busy, 0);

    // 2: fairness with all four requesting continuously
    do_reset();
    grant_log.delete();
    ag_raise_pct = 100; ag_hold_max = 0; ag_withdraw = 0;
    n = 0;
    while (grant_log.size() < 5 && n < 200) begin
      agents_step();
      tick(1);
      n++;
    end
    check("t2_count", (grant_log.size() >= 5), 1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("t2_order", grant_log[i], order_exp[i]);
    ag_raise_pct = 0;

    // 3: wrap and skip from pointer 3
    do_reset();
    bus.req = 4'b0100;
    wait_gnt(2, 1, 10, "t3_pre_grant");
    bus.req = '0;
    wait_gnt(2, 0, 10, "t3_pre_release");
    tick(2);
    grant_log.delete();
    bus.req = 4'b0011;
    wait_gnt(0, 1, 10, "t3_grant0");
    bus.req[0] = 1'b0;
    wait_gnt(1, 1, 10, "t3_grant1");
    bus.req[1] = 1'b0;
    wait_gnt(1, 0, 10, "t3_release1");
    tick(6);
    check("t3_log_size", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t3_first", grant_log[0], 0);
      check("t3_second", grant_log[1], 1);
    end

    // 4: timeout after HOLD_LIMIT cycles of grant, then clear
    do_reset();
    bus.req = 4'b0010;
    wait_gnt(1, 1, 10, "t4_grant");
    check("t4_to_c1", bus.timeout, 0);
    for (int k = 2; k <= 10; k++) begin
      tick(1);
      check("t4_to", bus.timeout, (k >= 6));
      check("t4_gnt_held", bus.gnt, 4'b0010);
    end
    bus.req = '0;
    wait_gnt(1, 0, 10, "t4_release");
    tick(2);
    check("t4_sticky", bus.timeout, 1);
    bus.timeout_clr = 1'b1;
    tick(1);
    bus.timeout_clr = 1'b0;
    check("t4_cleared", bus.timeout, 0);

    // 5: asynchronous reset mid-grant, then re-grant
    do_reset();
    bus.req = 4'b0100;
    wait_gnt(2, 1, 10, "t5_grant");
    tick(7);
    check("t5_to_before", bus.timeout, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", bus.gnt, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_timeout", bus.timeout, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_regrant_early", bus.gnt, 0);
    @(posedge clk); #1;
    check("t5_regrant", bus.gnt, 4'b0100);
    check("t5_regrant_owner", bus.owner, 2);

    // 6: short withdrawn request while requester 0 owns
    do_reset();
    saw_gnt3 = 0;
    bus.req = 4'b0001;
    wait_gnt(0, 1, 10, "t6_grant0");
    tick(2);
    bus.req[3] = 1'b1;
    tick(1);
    bus.req[3] = 1'b0;
    tick(5);
    bus.req[0] = 1'b0;
    tick(12);
    check("t6_no_gnt3", saw_gnt3, 0);
    check("t6_idle", bus.busy, 0);

    // Random traffic with withdrawals and clear pulses
    do_reset();
    ag_raise_pct = 30; ag_hold_max = 12; ag_withdraw = 1;
    repeat (3000) begin
      agents_step();
      bus.timeout_clr = ($urandom_range(0, 19) == 0);
      tick(1);
    end
    bus.timeout_clr = 1'b0;
    @(negedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mutex_arbiter.md
Name: mutex_arbiter

Overview:
- Clocked N-way round-robin arbiter that shares one bridge resource between asynchronous requesters.
- Uses a four-phase (return-to-zero) req/gnt handshake and supersedes pairwise mutex cascades.
- Sits between the handshake-side request lines and the synchronous bridge datapath.
- Reports the current owner to the datapath mux and flags grants held for too long.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- SYNC_STAGES, 2: synchronizer flops per req input (≥2).
- IDW, 2: owner index width; must satisfy 2**IDW ≥ N_REQ.
- HOLD_LIMIT, 255: grant-hold cycles before timeout asserts; 0 disables timeout.
- CNTW, 8: hold counter width; must satisfy HOLD_LIMIT < 2**CNTW.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester four-phase request; asynchronous to clk.
- gnt  output  N_REQ  one-hot grant, registered.
- busy  output  1  high while any gnt bit is high.
- owner  output  IDW  index of the granted requester; valid while busy.
- timeout  output  1  sticky: current or past grant reached HOLD_LIMIT.
- timeout_clr  input  1  synchronous clear of timeout.

Behaviour:
- Reset (reset_n low, asynchronous): gnt=0, busy=0, owner=0, timeout=0, synchronizers=0, rr pointer=0, hold counter=0, state=IDLE. Reset mid-grant drops gnt immediately with no RELEASE cycle.
- Each req bit passes through SYNC_STAGES flops to give reqs. All decisions use reqs only.
- FSM has three states:
  - IDLE:
    - If reqs != 0, choose the first set bit searching from rr pointer upward, wrapping modulo N_REQ.
    - Next edge: gnt[sel]=1, owner=sel, busy=1, counter=0, go to GRANT.
    - Else stay in IDLE.
  - GRANT:
    - Hold gnt while reqs[owner]=1. Counter increments each cycle and saturates at 2**CNTW-1.
    - When the counter equals HOLD_LIMIT and HOLD_LIMIT≠0, set timeout. The grant is not revoked.
    - When reqs[owner]=0, next edge: gnt=0, busy=0, rr pointer=(owner+1) mod N_REQ, go to RELEASE.
  - RELEASE: one dead cycle with no grant, then IDLE. This guarantees gnt low is visible before any new grant (break-before-make).
- Latency:
  - req rise to gnt rise is SYNC_STAGES+1 clk edges, when the arbiter is idle.
  - req fall to gnt fall is SYNC_STAGES+1 edges.
  - Minimum gap between successive grants is 1 cycle (RELEASE).
- Handshake rule:
  - A requester raises req, waits for gnt, and holds req for the whole transaction.
  - It drops req, waits for gnt low, and only then may raise req again.
  - Non-owner req changes during GRANT/RELEASE are ignored until IDLE.
- Withdrawal: a req that drops before it is granted is simply never granted. No error is raised.
- Simultaneous requests: resolved strictly by the rr pointer. A pointer value that is ≥ N_REQ is treated as 0.
- timeout_clr: clears timeout on the next edge. If set and clear coincide in the same cycle, set wins.
- Invariant: popcount(gnt) ≤ 1 at all times. owner is only meaningful while busy=1.

Decomposition:
- Shared def.v holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2;
  - default SYNC_STAGES and HOLD_LIMIT constants.
- One sub-module, req_sync: a parameterized N-bit, SYNC_STAGES-deep synchronizer with async active-low reset. It is instantiated once.
- Round-robin selection is a function inside mutex_arbiter.

Test Plan:
1. Single request: reset, then req=4'b0100 held. Required: gnt=4'b0100 and owner=2 exactly 3 edges later (SYNC_STAGES=2). Drop req: gnt=0 3 edges later, busy=0.
2. Fairness: req=4'b1111 continuously, with each owner dropping and re-raising after seeing gnt low. Required: grant order 0,1,2,3,0. At least one gnt-low cycle between grants.
3. Wrap and skip: pointer=3, req=4'b0011. Required: grant to 0, then to 1. Requester 3 is never granted.
4. Timeout: HOLD_LIMIT=5, req[1] held 10 cycles. Required: timeout rises on the 6th GRANT cycle and gnt stays high. Pulse timeout_clr after release: timeout=0 next edge.
5. Reset mid-grant: reset_n low during GRANT. Required: gnt=0, busy=0, timeout=0 without a clk edge. After release of reset with req[2] still high, re-grant to 2 after SYNC_STAGES+1 edges.
6. Withdrawal: req[3] pulses high 1 cycle while requester 0 owns the grant. Required: requester 3 is never granted, and no gnt glitch occurs on bit 3.
